// File: rtl/mont_mult_arbiter.sv
// mont_mult_arbiter
//   Shares one Montgomery multiplier core between NREQ requesters.
//   Single-cycle start pulses are captured into a pending vector, served
//   round-robin, and each finished operation is reported by a one-cycle
//   done pulse on the requester's bit together with the shared result.
//
// Ports
//   clk          clock, all logic on the rising edge
//   resetn       asynchronous active-low reset (shared with the core)
//   req_start    per-requester one-cycle start pulse
//   req_a/b/m    per-requester operands, requester i at [i*WIDTH +: WIDTH]
//   req_done     per-requester one-cycle completion pulse
//   result       last captured core result, shared by all requesters
//   grant_id     requester in service, zero-extended to 3 bits
//   busy         high whenever the arbiter is not idle
//   overrun      one-cycle pulse: start from a pending or in-service requester
//   mult_start   start pulse to the core
//   mult_a/b/m   registered core operands
//   mult_result  core result
//   mult_done    core completion flag (only looked at while waiting)
module mont_mult_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req_start,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*WIDTH-1:0] req_m,
    output logic [NREQ-1:0]       req_done,
    output logic [WIDTH-1:0]      result,
    output logic [2:0]            grant_id,
    output logic                  busy,
    output logic                  overrun,
    output logic                  mult_start,
    output logic [WIDTH-1:0]      mult_a,
    output logic [WIDTH-1:0]      mult_b,
    output logic [WIDTH-1:0]      mult_m,
    input  logic [WIDTH-1:0]      mult_result,
    input  logic                  mult_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [NREQ-1:0]    r_pending;
    logic [NREQ-1:0]    r_req_done;
    logic [2:0]         r_rr_ptr;
    logic [2:0]         r_grant_id;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_mult_a;
    logic [WIDTH-1:0]   r_mult_b;
    logic [WIDTH-1:0]   r_mult_m;
    logic               r_busy;
    logic               r_overrun;
    logic               r_mult_start;

    logic [NREQ-1:0]    w_gid_onehot;
    logic [NREQ-1:0]    w_insvc;
    logic [NREQ-1:0]    w_accept;
    logic [NREQ-1:0]    w_clr;
    logic               w_overrun;
    logic               w_found;
    logic [2:0]         w_pick;
    logic [2:0]         w_rr_next;

    // One-hot of the requester currently holding the core; only counts as
    // "in service" while busy, so a stale grant_id in IDLE blocks nothing.
    always_comb begin
        w_gid_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant_id == 3'(i)) begin
                w_gid_onehot[i] = 1'b1;
            end
        end
        w_insvc = r_busy ? w_gid_onehot : '0;
    end

    // Starts are accepted only against the registered pending vector, so a
    // start in the same cycle as a grant waits for the next round.
    assign w_accept  = req_start & ~r_pending & ~w_insvc;
    assign w_overrun = |(req_start & ~w_accept);

    // Round-robin pick: first pending index at or after rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && r_pending[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_pick  = 3'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    // Pending bit of the requester being granted on this edge.
    always_comb begin
        w_clr = '0;
        if (r_state == S_IDLE && w_found) begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_pick == 3'(i)) begin
                    w_clr[i] = 1'b1;
                end
            end
        end
    end

    assign w_rr_next = (r_grant_id == 3'(NREQ - 1)) ? 3'd0 : r_grant_id + 3'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_rr_ptr     <= 3'd0;
            r_grant_id   <= 3'd0;
            r_req_done   <= '0;
            r_result     <= '0;
            r_mult_a     <= '0;
            r_mult_b     <= '0;
            r_mult_m     <= '0;
            r_mult_start <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun    <= w_overrun;
            r_pending    <= (r_pending & ~w_clr) | w_accept;
            r_mult_start <= 1'b0;
            r_req_done   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id   <= w_pick;
                        r_mult_a     <= req_a[int'(w_pick)*WIDTH +: WIDTH];
                        r_mult_b     <= req_b[int'(w_pick)*WIDTH +: WIDTH];
                        r_mult_m     <= req_m[int'(w_pick)*WIDTH +: WIDTH];
                        r_mult_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    // mult_start is high during this state only; a stale
                    // done from the core is not looked at here.
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mult_done) begin
                        r_result   <= mult_result;
                        r_req_done <= w_gid_onehot;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_rr_ptr <= w_rr_next;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_done   = r_req_done;
    assign result     = r_result;
    assign grant_id   = r_grant_id;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign mult_start = r_mult_start;
    assign mult_a     = r_mult_a;
    assign mult_b     = r_mult_b;
    assign mult_m     = r_mult_m;

endmodule
